// File: rtl/ibpl_act_scheduler_pkg.sv
// Shared types and helpers for the interbackplane activity scheduler.
package ibpl_sched_pkg;

    localparam int CARDLET_IN_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        VISIT = 1'b1
    } sched_state_e;

    // Stretch counter width; a stretch of 1 still needs one bit.
    function automatic int cnt_width(input int stretch);
        return (stretch < 1) ? 1 : $clog2(stretch + 1);
    endfunction

endpackage

// File: rtl/ibpl_act_scheduler_edge_capture.sv
// Per-slot edge detector: prev/pending registers, pending is set-over-clear on a visit.
module ibpl_edge_capture
    import ibpl_sched_pkg::*;
#(
    parameter int N_CH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CARDLET_IN_W-1:0] in_i,
    input  logic [N_CH-1:0]         en_i,
    input  logic                    visit_i,
    output logic [N_CH-1:0]         pending_o
);

    logic            primed_q;
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] pend_q;
    logic [N_CH-1:0] pend_d;
    logic [N_CH-1:0] edge_w;

    // The first cycle after reset only loads prev, so static high inputs never look like edges.
    assign edge_w    = primed_q ? ((in_i[N_CH-1:0] ^ prev_q) & en_i) : '0;
    assign pend_d    = (visit_i ? '0 : pend_q) | edge_w;
    assign pending_o = pend_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_q <= 1'b0;
            prev_q   <= '0;
            pend_q   <= '0;
        end else begin
            primed_q <= 1'b1;
            prev_q   <= in_i[N_CH-1:0];
            pend_q   <= pend_d;
        end
    end

    generate
        if (N_CH < CARDLET_IN_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^in_i[CARDLET_IN_W-1:N_CH];
        end
    endgenerate

endmodule

// File: rtl/ibpl_act_scheduler.sv
// Round-robin activity scheduler: stretches captured edges into LED activity and arbitrates plugin errors.
module ibpl_act_scheduler
    import ibpl_sched_pkg::*;
#(
    parameter  int N_SLOTS       = 12,
    parameter  int N_CH          = 6,
    parameter  int STRETCH_SCANS = 3,
    localparam int SLOT_W        = $clog2(N_SLOTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             scan_tick,
    input  logic [N_SLOTS*CARDLET_IN_W-1:0]  internal_in,
    input  logic [N_SLOTS*N_CH-1:0]          input_enable,
    input  logic [N_SLOTS-1:0]               plugin_error,
    input  logic                             err_clr,
    output logic [N_SLOTS*N_CH-1:0]          input_act,
    output logic                             err_any,
    output logic [SLOT_W-1:0]                err_slot,
    output logic                             scan_busy,
    output logic                             scan_wrap,
    output logic                             tick_overrun
);

    localparam int                CNT_W    = cnt_width(STRETCH_SCANS);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(STRETCH_SCANS);
    localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(N_SLOTS - 1);

    sched_state_e       state_q, state_d;
    logic [SLOT_W-1:0]  idx_q, idx_d;
    logic               visit;
    logic [N_SLOTS-1:0] visit_s;
    logic [N_CH-1:0]    pending [N_SLOTS];
    logic [CNT_W-1:0]   cnt_q   [N_SLOTS][N_CH];
    logic [CNT_W-1:0]   cnt_d   [N_SLOTS][N_CH];
    logic               err_any_q, err_any_d;
    logic [SLOT_W-1:0]  err_slot_q, err_slot_d;
    logic               overrun_q, overrun_d;
    logic [SLOT_W-1:0]  low_idx;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        visit     = 1'b0;
        scan_wrap = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_tick) begin
                    state_d = VISIT;
                    idx_d   = '0;
                end
            end
            VISIT: begin
                visit = 1'b1;
                if (idx_q == LAST_IDX) begin
                    scan_wrap = 1'b1;
                    state_d   = IDLE;
                    idx_d     = '0;
                end else begin
                    idx_d = idx_q + SLOT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign scan_busy = (state_q == VISIT);

    generate
        for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
            assign visit_s[s] = visit && (idx_q == SLOT_W'(s));
            ibpl_edge_capture #(.N_CH(N_CH)) u_cap (
                .clk       (clk),
                .rst       (rst),
                .in_i      (internal_in[s*CARDLET_IN_W +: CARDLET_IN_W]),
                .en_i      (input_enable[s*N_CH +: N_CH]),
                .visit_i   (visit_s[s]),
                .pending_o (pending[s])
            );
        end
    endgenerate

    // The visit consumes the pending value registered before this edge; a coinciding edge survives.
    always_comb begin
        cnt_d = cnt_q;
        for (int s = 0; s < N_SLOTS; s++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (visit_s[s]) begin
                    if (!input_enable[s*N_CH + c])  cnt_d[s][c] = '0;
                    else if (pending[s][c])          cnt_d[s][c] = CNT_LOAD;
                    else if (cnt_q[s][c] != '0)      cnt_d[s][c] = cnt_q[s][c] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        input_act = '0;
        for (int s = 0; s < N_SLOTS; s++)
            for (int c = 0; c < N_CH; c++)
                input_act[s*N_CH + c] = (cnt_q[s][c] != '0) && input_enable[s*N_CH + c];
    end

    always_comb begin
        low_idx = '0;
        for (int s = N_SLOTS - 1; s >= 0; s--)
            if (plugin_error[s]) low_idx = SLOT_W'(s);
    end

    // A live plugin error outranks err_clr so a fault can never be silently dropped.
    always_comb begin
        err_any_d  = err_any_q;
        err_slot_d = err_slot_q;
        overrun_d  = overrun_q;
        if (err_clr) begin
            err_any_d  = 1'b0;
            err_slot_d = '0;
            overrun_d  = 1'b0;
        end
        if (|plugin_error && (!err_any_q || err_clr)) begin
            err_any_d  = 1'b1;
            err_slot_d = low_idx;
        end
        if (scan_tick && state_q == VISIT) overrun_d = 1'b1;
    end

    assign err_any      = err_any_q;
    assign err_slot     = err_slot_q;
    assign tick_overrun = overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            err_any_q  <= 1'b0;
            err_slot_q <= '0;
            overrun_q  <= 1'b0;
            for (int s = 0; s < N_SLOTS; s++)
                for (int c = 0; c < N_CH; c++)
                    cnt_q[s][c] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_any_q  <= err_any_d;
            err_slot_q <= err_slot_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ibpl_act_scheduler.sv
// Directed self-checking bench for ibpl_act_scheduler (default parameters).
module tb_ibpl_act_scheduler;

    localparam int N_SLOTS = 12;
    localparam int N_CH    = 6;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  scan_tick;
    logic [N_SLOTS*8-1:0]  internal_in;
    logic [N_SLOTS*N_CH-1:0] input_enable;
    logic [N_SLOTS-1:0]    plugin_error;
    logic                  err_clr;
    logic [N_SLOTS*N_CH-1:0] input_act;
    logic                  err_any;
    logic [3:0]            err_slot;
    logic                  scan_busy;
    logic                  scan_wrap;
    logic                  tick_overrun;

    int n_pass   = 0;
    int n_total  = 0;
    int wrap_cnt = 0;
    bit count_wraps = 1'b0;

    always #5 clk = ~clk;

    ibpl_act_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .scan_tick    (scan_tick),
        .internal_in  (internal_in),
        .input_enable (input_enable),
        .plugin_error (plugin_error),
        .err_clr      (err_clr),
        .input_act    (input_act),
        .err_any      (err_any),
        .err_slot     (err_slot),
        .scan_busy    (scan_busy),
        .scan_wrap    (scan_wrap),
        .tick_overrun (tick_overrun)
    );

    always @(negedge clk) if (count_wraps && scan_wrap) wrap_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic act(input int s, input int c);
        return input_act[s*N_CH + c];
    endfunction

    task automatic toggle_in(input int s, input int c);
        internal_in[s*8 + c] = ~internal_in[s*8 + c];
    endtask

    task automatic steps(input int n);
        repeat (n) @(negedge clk);
    endtask

    // After this returns the FSM is in VISIT with idx=0.
    task automatic start_tick();
        scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
    endtask

    task automatic run_pass();
        start_tick();
        steps(12);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst          = 1'b1;
        scan_tick    = 1'b0;
        internal_in  = '0;
        internal_in[1*8 + 1] = 1'b1;
        input_enable = '1;
        plugin_error = '0;
        err_clr      = 1'b0;
        steps(2);
        rst = 1'b0;
        #1;
        check("reset_act",     input_act, 0);
        check("reset_err_any", err_any, 0);
        check("reset_err_slt", err_slot, 0);
        check("reset_busy",    scan_busy, 0);
        check("reset_wrap",    scan_wrap, 0);
        check("reset_overrun", tick_overrun, 0);
        steps(1);

        // Three idle passes: wrap latency, busy flag, wrap count
        count_wraps = 1'b1;
        for (int i = 0; i < 3; i++) begin
            scan_tick = 1'b1;
            cyc = 0;
            do begin
                @(negedge clk);
                scan_tick = 1'b0;
                cyc++;
                if (cyc == 1) check("busy_in_pass", scan_busy, 1);
            end while (!scan_wrap && cyc < 40);
            check("wrap_latency", cyc, 12);
            @(negedge clk);
            check("idle_after_wrap", scan_busy, 0);
        end
        steps(2);
        count_wraps = 1'b0;
        check("wrap_count", wrap_cnt, 3);
        check("idle_act_zero", input_act, 0);
        check("idle_err_zero", err_any, 0);

        // Slot 4 ch2 single edge, stretched over three passes
        toggle_in(4, 2);
        steps(1);
        start_tick();
        steps(4);
        check("s4c2_before_visit", act(4, 2), 0);
        steps(1);
        check("s4c2_after_visit", act(4, 2), 1);
        steps(7);
        check("s4c2_only_bit", input_act, 72'h1 << 26);
        run_pass();
        check("s4c2_pass2", act(4, 2), 1);
        run_pass();
        check("s4c2_pass3", act(4, 2), 1);
        start_tick();
        steps(4);
        check("s4c2_pass4_pre", act(4, 2), 1);
        steps(1);
        check("s4c2_pass4_post", act(4, 2), 0);
        steps(7);

        // Slot 0 ch0: new edge on the visit cycle while pending is already set
        toggle_in(0, 0);
        steps(1);
        start_tick();
        toggle_in(0, 0);
        steps(12);
        check("s0c0_pass1", act(0, 0), 1);
        run_pass();
        run_pass();
        run_pass();
        check("s0c0_reloaded", act(0, 0), 1);
        run_pass();
        check("s0c0_expired", act(0, 0), 0);

        // Slot 7 ch5: disable gates output immediately, visit clears the counter
        toggle_in(7, 5);
        steps(1);
        run_pass();
        run_pass();
        check("s7c5_cnt2", act(7, 5), 1);
        input_enable[7*N_CH + 5] = 1'b0;
        #1;
        check("s7c5_gate", act(7, 5), 0);
        run_pass();
        input_enable[7*N_CH + 5] = 1'b1;
        #1;
        check("s7c5_reenable", act(7, 5), 0);
        run_pass();
        check("s7c5_no_edge", act(7, 5), 0);

        // Error arbitration
        plugin_error = 12'h208;
        steps(1);
        check("err_any_set", err_any, 1);
        check("err_lowest", err_slot, 3);
        plugin_error = 12'h20C;
        steps(1);
        check("err_slot_hold", err_slot, 3);
        plugin_error = 12'h200;
        err_clr = 1'b1;
        steps(1);
        err_clr = 1'b0;
        check("err_clr_relatch_any", err_any, 1);
        check("err_clr_relatch_slot", err_slot, 9);
        plugin_error = '0;
        err_clr = 1'b1;
        steps(1);
        err_clr = 1'b0;
        check("err_cleared_any", err_any, 0);
        check("err_cleared_slot", err_slot, 0);

        // Tick overrun mid-pass and on the wrap cycle
        start_tick();
        steps(4);
        scan_tick = 1'b1;
        steps(1);
        scan_tick = 1'b0;
        check("overrun_set", tick_overrun, 1);
        check("overrun_busy", scan_busy, 1);
        steps(6);
        check("overrun_wrap", scan_wrap, 1);
        scan_tick = 1'b1;
        steps(1);
        scan_tick = 1'b0;
        check("wrap_tick_ignored", scan_busy, 0);
        steps(3);
        check("no_second_pass", scan_busy, 0);
        check("overrun_sticky", tick_overrun, 1);
        err_clr = 1'b1;
        steps(1);
        err_clr = 1'b0;
        check("overrun_cleared", tick_overrun, 0);

        // Reset in the middle of a pass
        toggle_in(2, 3);
        steps(1);
        run_pass();
        check("s2c3_active", act(2, 3), 1);
        start_tick();
        steps(2);
        plugin_error = 12'h001;
        steps(1);
        check("pre_rst_err", err_any, 1);
        rst = 1'b1;
        #1;
        check("rst_busy", scan_busy, 0);
        check("rst_act", input_act, 0);
        check("rst_err", err_any, 0);
        plugin_error = '0;
        steps(1);
        rst = 1'b0;
        steps(1);
        run_pass();
        check("post_rst_no_edge", input_act, 0);
        check("post_rst_err", err_any, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
